shift_counter_gen: RTL

Parametrised shift-register counter generalising the team's fixed 8-bit Johnson counter. Supports Johnson (twisted-ring) and one-hot ring modes at any width, counts in both directions, and accepts enable and parallel load. It self-corrects illegal states and reports a decoded phase index and a wrap pulse. It is the sequence/phase generator for downstream multi-phase control logic.

---
 rtl/shift_counter_gen.sv | 126 ++++++++++++
 1 files changed

// File: rtl/shift_counter_gen.sv
// rtl/shift_counter_gen.sv - parametrised Johnson/ring shift counter with phase decode
//
// Purpose: generates a Johnson (2*WIDTH states) or one-hot ring (WIDTH states)
// sequence, up or down, with enable, parallel load, self-correction of illegal
// states, a decoded phase index and registered wrap / illegal pulses.
//
// Ports:
//   clk      - rising-edge clock
//   rst      - synchronous active-low reset
//   en       - count enable, one step per cycle
//   dir      - 0 = up, 1 = down
//   mode     - 0 = Johnson, 1 = ring
//   load     - parallel load strobe (beats en)
//   load_val - value written verbatim on load
//   q        - registered counter state
//   phase    - position of q in the current mode's sequence (0 when illegal)
//   wrap     - one-cycle pulse after a step that wrapped the sequence
//   illegal  - one-cycle pulse after an illegal state was corrected
module shift_counter_gen #(
    parameter int WIDTH = 8,
    parameter int PW    = $clog2(2*WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             dir,
    input  logic             mode,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic [PW-1:0]    phase,
    output logic             wrap,
    output logic             illegal
);

    localparam logic [PW-1:0] LAST_J = PW'(2*WIDTH - 1);
    localparam logic [PW-1:0] LAST_R = PW'(WIDTH - 1);

    logic [WIDTH-1:0] r_q;
    logic             r_wrap;
    logic             r_illegal;

    logic [WIDTH-1:0] w_nq;
    logic             w_is_mask_q;
    logic             w_is_mask_nq;
    logic             w_onehot;
    logic             w_legal;
    logic [PW-1:0]    w_ones;
    logic [PW-1:0]    w_zeros;
    logic [PW-1:0]    w_ring_idx;
    logic [PW-1:0]    w_phase_j;
    logic [PW-1:0]    w_phase;
    logic             w_at_end;
    logic [WIDTH-1:0] w_step;
    logic [WIDTH-1:0] w_home;

    // A value is a low-order mask (2^k - 1) exactly when adding one clears
    // every set bit; Johnson legality is "q or ~q is such a mask".
    assign w_nq         = ~r_q;
    assign w_is_mask_q  = ((r_q  & (r_q  + WIDTH'(1))) == '0);
    assign w_is_mask_nq = ((w_nq & (w_nq + WIDTH'(1))) == '0);
    assign w_onehot     = (r_q != '0) && ((r_q & (r_q - WIDTH'(1))) == '0);
    assign w_legal      = mode ? w_onehot : (w_is_mask_q | w_is_mask_nq);

    // For legal patterns the popcounts equal the contiguous run lengths.
    always_comb begin
        w_ones     = '0;
        w_zeros    = '0;
        w_ring_idx = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_ones  = w_ones  + PW'(r_q[i]);
            w_zeros = w_zeros + PW'(w_nq[i]);
            if (r_q[i]) begin
                w_ring_idx = PW'(i);
            end
        end
    end

    // All-zeros and all-ones are both masks; checking q first gives them 0 and W.
    assign w_phase_j = w_is_mask_q ? w_ones : (PW'(WIDTH) + w_zeros);
    assign w_phase   = !w_legal ? '0 : (mode ? w_ring_idx : w_phase_j);

    assign w_at_end  = dir ? (w_phase == '0) : (w_phase == (mode ? LAST_R : LAST_J));

    always_comb begin
        w_step = r_q;
        if (dir) begin
            w_step = {(mode ? r_q[0] : ~r_q[0]), r_q[WIDTH-1:1]};
        end else begin
            w_step = {r_q[WIDTH-2:0], (mode ? r_q[WIDTH-1] : ~r_q[WIDTH-1])};
        end
    end

    assign w_home = mode ? WIDTH'(1) : '0;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_q       <= w_home;
            r_wrap    <= 1'b0;
            r_illegal <= 1'b0;
        end else if (load) begin
            r_q       <= load_val;
            r_wrap    <= 1'b0;
            r_illegal <= 1'b0;
        end else if (en) begin
            if (w_legal) begin
                r_q       <= w_step;
                r_wrap    <= w_at_end;
                r_illegal <= 1'b0;
            end else begin
                r_q       <= w_home;
                r_wrap    <= 1'b0;
                r_illegal <= 1'b1;
            end
        end else begin
            r_wrap    <= 1'b0;
            r_illegal <= 1'b0;
        end
    end

    assign q       = r_q;
    assign phase   = w_phase;
    assign wrap    = r_wrap;
    assign illegal = r_illegal;

endmodule
